// File: rtl/demux1t4_8b_reg.sv
// Purpose: registered 1:4 demux; steers one WIDTH-bit word per handshake into one of four one-entry buffers (A..D).
// Latency: a word appears on its channel output, with Out_valid set, one cycle after it is accepted.
// Backpressure: In_ready drops when the destination buffer is full and its consumer is not taking the word this cycle.
// Optional feature (macro DEMUX_AUTO_SEL_EN): the destination comes from an internal round-robin pointer and Sel is ignored.
module demux1t4_8b_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In_data,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [1:0]       Sel,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       Out_valid,
    input  logic [3:0]       Out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state_q [4];
    chan_state_t      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [1:0]       dest;
    logic             accept;
    logic [3:0]       load;
    logic [3:0]       drain;

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] ptr_q;

    // Round-robin destination pointer: advances on every accepted word, wraps naturally at 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else if (accept) begin
            ptr_q <= ptr_q + 2'd1;
        end
    end

    assign dest = ptr_q;
`else
    assign dest = Sel;
`endif

    // Ready looks only at the destination buffer; a full buffer that drains this cycle can take a new word.
    always_comb begin
        In_ready = (state_q[dest] == EMPTY) | Out_ready[dest];
    end

    assign accept = In_valid & In_ready;

    // Per-channel load/drain strobes.
    always_comb begin
        load  = 4'b0000;
        drain = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            load[i]  = accept & (dest == 2'(i));
            drain[i] = (state_q[i] == FULL) & Out_ready[i];
        end
    end

    // Channel FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Channel FSM next state: a load always leaves the buffer full, a drain without a load empties it.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                EMPTY:   if (load[i]) state_d[i] = FULL;
                FULL:    if (drain[i] && !load[i]) state_d[i] = EMPTY;
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    // Channel FSM outputs: valid mirrors the FULL state.
    always_comb begin
        Out_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            Out_valid[i] = (state_q[i] == FULL);
        end
    end

    // Channel data registers: written only on a load; kept (not cleared) after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i] <= In_data;
                end
            end
        end
    end

    assign A = data_q[0];
    assign B = data_q[1];
    assign C = data_q[2];
    assign D = data_q[3];

endmodule

// File: tb/tb_demux1t4_8b_reg.sv
// Bench for demux1t4_8b_reg: vector table plus a hand-written stall sequence.
// Inputs change on the falling edge; In_ready is checked before the rising edge, registered outputs after it.
// The table contents follow the DEMUX_AUTO_SEL_EN setting of the build.
module tb_demux1t4_8b_reg;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sel;
    logic [7:0] a, b, c, d;
    logic [3:0] out_valid;
    logic [3:0] out_ready;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] sel;
        logic [7:0] dat;
        logic [3:0] ordy;
        logic       chk_rdy;
        logic       exp_rdy;
        logic [3:0] exp_vld;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_c;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl[$];

    demux1t4_8b_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .In_data   (in_data),
        .In_valid  (in_valid),
        .In_ready  (in_ready),
        .Sel       (sel),
        .A         (a),
        .B         (b),
        .C         (c),
        .D         (d),
        .Out_valid (out_valid),
        .Out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [1:0] s, input logic [7:0] dt,
                       input logic [3:0] o, input logic cr, input logic er, input logic [3:0] ev,
                       input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                       input logic [7:0] ed);
        vec_t t;
        t.rst = r; t.vld = v; t.sel = s; t.dat = dt; t.ordy = o;
        t.chk_rdy = cr; t.exp_rdy = er; t.exp_vld = ev;
        t.exp_a = ea; t.exp_b = eb; t.exp_c = ec; t.exp_d = ed;
        tbl.push_back(t);
    endtask

    // Drive one cycle of inputs, check ready before the edge and registered state after it.
    task automatic step(input string tag, input vec_t t);
        rst       = t.rst;
        in_valid  = t.vld;
        sel       = t.sel;
        in_data   = t.dat;
        out_ready = t.ordy;
        #1;
        if (t.chk_rdy) check({tag, " in_ready"}, 32'(in_ready), 32'(t.exp_rdy));
        @(posedge clk);
        @(negedge clk);
        check({tag, " out_valid"}, 32'(out_valid), 32'(t.exp_vld));
        check({tag, " A"}, 32'(a), 32'(t.exp_a));
        check({tag, " B"}, 32'(b), 32'(t.exp_b));
        check({tag, " C"}, 32'(c), 32'(t.exp_c));
        check({tag, " D"}, 32'(d), 32'(t.exp_d));
    endtask

    initial begin
        vec_t h;
        tests_run    = 0;
        tests_failed = 0;

        //   rst v  sel    data   ordy     cr er vld      A      B      C      D
`ifdef DEMUX_AUTO_SEL_EN
        add(1, 1, 2'd3, 8'hFF, 4'b1111, 0, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        add(0, 1, 2'd3, 8'h10, 4'b1111, 1, 1, 4'b0001, 8'h10, 8'h00, 8'h00, 8'h00);
        add(0, 1, 2'd3, 8'h20, 4'b1111, 1, 1, 4'b0010, 8'h10, 8'h20, 8'h00, 8'h00);
        add(0, 1, 2'd3, 8'h30, 4'b1111, 1, 1, 4'b0100, 8'h10, 8'h20, 8'h30, 8'h00);
        add(0, 1, 2'd3, 8'h40, 4'b1111, 1, 1, 4'b1000, 8'h10, 8'h20, 8'h30, 8'h40);
        add(0, 1, 2'd3, 8'h50, 4'b1111, 1, 1, 4'b0001, 8'h50, 8'h20, 8'h30, 8'h40);
        add(0, 0, 2'd3, 8'h99, 4'b1111, 1, 1, 4'b0000, 8'h50, 8'h20, 8'h30, 8'h40);
        // pointer held at B while idle; B then C fill with consumers stalled
        add(0, 1, 2'd0, 8'h60, 4'b0000, 1, 1, 4'b0010, 8'h50, 8'h60, 8'h30, 8'h40);
        add(0, 1, 2'd1, 8'h70, 4'b0000, 1, 1, 4'b0110, 8'h50, 8'h60, 8'h70, 8'h40);
        add(0, 1, 2'd2, 8'h80, 4'b0000, 1, 1, 4'b1110, 8'h50, 8'h60, 8'h70, 8'h80);
        // pointer now at A (empty): accepted; next at B (full, stalled): refused
        add(0, 1, 2'd3, 8'h90, 4'b0000, 1, 1, 4'b1111, 8'h90, 8'h60, 8'h70, 8'h80);
        add(0, 1, 2'd3, 8'hA0, 4'b0000, 1, 0, 4'b1111, 8'h90, 8'h60, 8'h70, 8'h80);
        // reset mid-transfer discards everything
        add(1, 1, 2'd0, 8'hEE, 4'b0000, 0, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        add(0, 1, 2'd3, 8'hB0, 4'b0000, 1, 1, 4'b0001, 8'hB0, 8'h00, 8'h00, 8'h00);
`else
        add(1, 1, 2'd0, 8'hFF, 4'b1111, 0, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        // one word to each channel, all consumers ready
        add(0, 1, 2'd0, 8'h01, 4'b1111, 1, 1, 4'b0001, 8'h01, 8'h00, 8'h00, 8'h00);
        add(0, 1, 2'd1, 8'h02, 4'b1111, 1, 1, 4'b0010, 8'h01, 8'h02, 8'h00, 8'h00);
        add(0, 1, 2'd2, 8'h04, 4'b1111, 1, 1, 4'b0100, 8'h01, 8'h02, 8'h04, 8'h00);
        add(0, 1, 2'd3, 8'h08, 4'b1111, 1, 1, 4'b1000, 8'h01, 8'h02, 8'h04, 8'h08);
        add(0, 0, 2'd0, 8'h00, 4'b1111, 1, 1, 4'b0000, 8'h01, 8'h02, 8'h04, 8'h08);
        // A stalls: second word refused until Out_ready[0] rises
        add(0, 1, 2'd0, 8'hAA, 4'b0000, 1, 1, 4'b0001, 8'hAA, 8'h02, 8'h04, 8'h08);
        add(0, 1, 2'd0, 8'h55, 4'b0000, 1, 0, 4'b0001, 8'hAA, 8'h02, 8'h04, 8'h08);
        add(0, 1, 2'd0, 8'h55, 4'b0001, 1, 1, 4'b0001, 8'h55, 8'h02, 8'h04, 8'h08);
        // other channel accepted while A is stalled
        add(0, 1, 2'd2, 8'h33, 4'b0000, 1, 1, 4'b0101, 8'h55, 8'h02, 8'h33, 8'h08);
        // drain and reload A in the same cycle
        add(0, 1, 2'd0, 8'h77, 4'b0001, 1, 1, 4'b0101, 8'h77, 8'h02, 8'h33, 8'h08);
        // Sel changes while idle have no effect
        add(0, 0, 2'd0, 8'h99, 4'b0000, 1, 0, 4'b0101, 8'h77, 8'h02, 8'h33, 8'h08);
        add(0, 0, 2'd1, 8'h99, 4'b0000, 1, 1, 4'b0101, 8'h77, 8'h02, 8'h33, 8'h08);
        // simultaneous drain of A and C; data kept
        add(0, 0, 2'd0, 8'h99, 4'b1111, 1, 1, 4'b0000, 8'h77, 8'h02, 8'h33, 8'h08);
        // A and D full, then reset with an In_valid pulse
        add(0, 1, 2'd0, 8'hA1, 4'b0000, 1, 1, 4'b0001, 8'hA1, 8'h02, 8'h33, 8'h08);
        add(0, 1, 2'd3, 8'hD1, 4'b0000, 1, 1, 4'b1001, 8'hA1, 8'h02, 8'h33, 8'hD1);
        add(1, 1, 2'd1, 8'hEE, 4'b0000, 0, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        add(0, 0, 2'd0, 8'h00, 4'b0000, 1, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        // back-to-back to B with consumer ready
        add(0, 1, 2'd1, 8'h11, 4'b1111, 1, 1, 4'b0010, 8'h00, 8'h11, 8'h00, 8'h00);
        add(0, 1, 2'd1, 8'h22, 4'b1111, 1, 1, 4'b0010, 8'h00, 8'h22, 8'h00, 8'h00);
        add(0, 0, 2'd1, 8'h00, 4'b1111, 1, 1, 4'b0000, 8'h00, 8'h22, 8'h00, 8'h00);
`endif

        rst = 1'b1; in_valid = 1'b0; sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

`ifndef DEMUX_AUTO_SEL_EN
        // Stall sequence on C: valid not visible in the accept cycle, held for several cycles.
        rst = 1'b0; in_valid = 1'b1; sel = 2'd2; in_data = 8'hC1; out_ready = 4'b0000;
        #1;
        check("stall accept rdy", 32'(in_ready), 32'd1);
        check("stall same-cycle vld", 32'(out_valid), 32'b0000);
        @(posedge clk);
        @(negedge clk);
        check("stall load vld", 32'(out_valid), 32'b0100);
        check("stall load C", 32'(c), 32'hC1);
        for (int k = 0; k < 4; k++) begin
            in_data = 8'hC2 + 8'(k);
            #1;
            check($sformatf("stall%0d rdy", k), 32'(in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("stall%0d C", k), 32'(c), 32'hC1);
            check($sformatf("stall%0d vld", k), 32'(out_valid), 32'b0100);
        end
        h.rst = 0; h.vld = 1; h.sel = 2'd2; h.dat = 8'hCF; h.ordy = 4'b0100;
        h.chk_rdy = 1; h.exp_rdy = 1; h.exp_vld = 4'b0100;
        h.exp_a = 8'h00; h.exp_b = 8'h22; h.exp_c = 8'hCF; h.exp_d = 8'h00;
        step("stall release", h);
        h.vld = 0; h.exp_vld = 4'b0000;
        step("stall drain", h);
`else
        // Idle cycles with Sel toggling must not move the pointer (now at B, which is empty).
        for (int k = 0; k < 3; k++) begin
            h.rst = 0; h.vld = 0; h.sel = 2'(k); h.dat = 8'h00; h.ordy = 4'b0000;
            h.chk_rdy = 1; h.exp_rdy = 1; h.exp_vld = 4'b0001;
            h.exp_a = 8'hB0; h.exp_b = 8'h00; h.exp_c = 8'h00; h.exp_d = 8'h00;
            step($sformatf("idle%0d", k), h);
        end
        h.vld = 1; h.dat = 8'hB1; h.exp_vld = 4'b0011; h.exp_b = 8'hB1;
        step("after idle", h);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
